// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud detector.
// Also reusable by the uart_rx/uart_tx benches.
package uart_autobaud_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WAIT_START,
        ST_MEASURE,
        ST_DONE
    } ab_state_t;

    localparam logic [7:0] SYNC_CHAR      = 8'h55;
    localparam int         PRESCALE_SHIFT = 6;
    localparam int         ROUND_BIAS     = 1 << (PRESCALE_SHIFT - 1);

endpackage

// File: rtl/uart_autobaud_sync_edge.sv
// Two-flop synchronizer with falling-edge detect on the synchronized line.
// Flops reset high so an idle line never produces a spurious edge.
module uart_autobaud_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times five falling edges of a 0x55 sync character
// and converts the 8-bit-time span into a UART prescale (span/64, rounded).
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int          COUNT_WIDTH      = 24,
    parameter int          MIN_IDLE         = 16,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        arm,
    output logic [15:0] prescale_out,
    output logic        prescale_valid,
    output logic        done,
    output logic        error,
    output logic        busy
);

    localparam int IW = $clog2(MIN_IDLE + 1);
    localparam int PW = (COUNT_WIDTH + 1 > 17) ? COUNT_WIDTH + 1 : 17;
    localparam logic [COUNT_WIDTH-1:0] SPAN_MAX = '1;

    ab_state_t r_state;
    ab_state_t w_next;

    logic                   w_rx;
    logic                   w_fall;
    logic [IW-1:0]          r_idle_cnt;
    logic [COUNT_WIDTH-1:0] r_span;
    logic [COUNT_WIDTH-1:0] r_int;
    logic [COUNT_WIDTH-1:0] r_i1;
    logic [1:0]             r_edges;
    logic                   r_err;
    logic [15:0]            r_prescale;
    logic                   r_valid;

    logic                   w_timeout;
    logic                   w_idle_ok;
    logic [COUNT_WIDTH-1:0] w_int_now;
    logic [COUNT_WIDTH-1:0] w_dev;
    logic                   w_unstable;
    logic [PW-1:0]          w_sum;
    logic [PW-1:0]          w_p;
    logic                   w_p_bad;
    logic                   w_reject;

    uart_autobaud_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (rxd),
        .o_q    (w_rx),
        .o_fall (w_fall)
    );

    assign w_timeout = (r_span == SPAN_MAX);
    assign w_idle_ok = w_rx && (r_idle_cnt == IW'(MIN_IDLE - 1));

    // Interval including the current edge cycle, and its deviation from I1
    assign w_int_now  = r_int + COUNT_WIDTH'(1);
    assign w_dev      = (w_int_now >= r_i1) ? (w_int_now - r_i1)
                                            : (r_i1 - w_int_now);
    assign w_unstable = (w_dev > (r_i1 >> 2));

    assign w_sum    = PW'(r_span) + PW'(ROUND_BIAS);
    assign w_p      = w_sum >> PRESCALE_SHIFT;
    assign w_p_bad  = (w_p == '0) || (w_p > PW'(17'h0FFFF));
    assign w_reject = r_err || w_p_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        done   = 1'b0;
        error  = 1'b0;
        busy   = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (arm) w_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (w_idle_ok) w_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_timeout)   w_next = ST_DONE;
                else if (w_fall) w_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_timeout)                         w_next = ST_DONE;
                else if (w_fall && r_edges == 2'd3)    w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                error  = w_reject;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_span     <= '0;
            r_int      <= '0;
            r_i1       <= '0;
            r_edges    <= '0;
            r_err      <= 1'b0;
            r_prescale <= DEFAULT_PRESCALE;
            r_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    r_err      <= 1'b0;
                end
                ST_WAIT_IDLE: begin
                    r_idle_cnt <= w_rx ? r_idle_cnt + IW'(1) : '0;
                    r_span     <= '0;
                end
                ST_WAIT_START: begin
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end else if (w_fall) begin
                        r_span  <= '0;
                        r_int   <= '0;
                        r_edges <= '0;
                    end else begin
                        r_span <= r_span + COUNT_WIDTH'(1);
                    end
                end
                ST_MEASURE: begin
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_span <= r_span + COUNT_WIDTH'(1);
                        if (w_fall) begin
                            r_int   <= '0;
                            r_edges <= r_edges + 2'd1;
                            if (r_edges == 2'd0) r_i1  <= w_int_now;
                            else if (w_unstable) r_err <= 1'b1;
                        end else begin
                            r_int <= r_int + COUNT_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!w_reject) begin
                        r_prescale <= w_p[15:0];
                        r_valid    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prescale_out   = r_prescale;
    assign prescale_valid = r_valid;

endmodule
